// File: rtl/pcie_phy_pkg.sv
// Shared 128b/130b PHY definitions: sync headers, ordered-set identifiers,
// block-type and lock-state enums used by the lane sequencing controllers.
package pcie_phy_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_OS   = 2'b01;

  localparam logic [7:0] OS_EIEOS = 8'h00;
  localparam logic [7:0] OS_SKP   = 8'hAA;
  localparam logic [7:0] OS_EIOS  = 8'h66;

  typedef enum logic [2:0] {
    BLK_DATA,
    BLK_SKP,
    BLK_EIEOS,
    BLK_EIOS,
    BLK_OTHER_OS,
    BLK_INVALID
  } blk_type_e;

  typedef enum logic {
    ST_HUNT,
    ST_LOCKED
  } lock_state_e;

endpackage

// File: rtl/pcie_blk_classify.sv
// Combinational 130-bit block classifier: sync header plus symbol 0 to block type.
// Shared between the receive descrambler and transmit scrambler controllers.
module pcie_blk_classify
  import pcie_phy_pkg::*;
(
  input  logic [1:0] in_sync,
  input  logic [7:0] sym0,
  output blk_type_e  blk_type
);

  always_comb begin
    blk_type = BLK_INVALID;
    if (in_sync == SYNC_DATA) begin
      blk_type = BLK_DATA;
    end else if (in_sync == SYNC_OS) begin
      case (sym0)
        OS_EIEOS: blk_type = BLK_EIEOS;
        OS_SKP:   blk_type = BLK_SKP;
        OS_EIOS:  blk_type = BLK_EIOS;
        default:  blk_type = BLK_OTHER_OS;
      endcase
    end
  end

endmodule

// File: rtl/pcie_descrambler_ctrl.sv
// Per-lane block-lock controller in front of the 128b/130b descrambler: gates
// payload, drives bypass and LFSR load/hold sidebands, and counts bad headers.
module pcie_descrambler_ctrl
  import pcie_phy_pkg::*;
#(
  parameter int DW        = 128,
  parameter int ERR_LIMIT = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0]        in_data,
  input  logic [1:0]           in_sync,
  input  logic                 in_valid,
  input  logic                 cfg_enable,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  output logic                 out_is_ctl,
  output logic                 out_lfsr_load,
  output logic                 out_lfsr_hold,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  blk_type_e             blk_type_p0;
  lock_state_e           state, state_n;
  logic [3:0]            consec, consec_n;
  logic [ERR_CNT_W-1:0]  err_cnt_n;
  logic                  vld_n, ctl_n, load_n, hold_n, errp_n;

  logic [DW-1:0]         data_p1;
  logic                  vld_p1, ctl_p1, load_p1, hold_p1, errp_p1, locked_p1;
  logic [ERR_CNT_W-1:0]  err_cnt_p1;

  pcie_blk_classify u_classify (
    .in_sync  (in_sync),
    .sym0     (in_data[7:0]),
    .blk_type (blk_type_p0)
  );

  always_comb begin
    state_n   = state;
    consec_n  = consec;
    err_cnt_n = err_cnt_p1;
    vld_n     = 1'b0;
    ctl_n     = 1'b0;
    load_n    = 1'b0;
    hold_n    = 1'b0;
    errp_n    = 1'b0;
    // A disabled lane wins over whatever block arrives in the same cycle.
    if (!cfg_enable) begin
      state_n  = ST_HUNT;
      consec_n = '0;
    end else if (in_valid) begin
      if (blk_type_p0 != BLK_INVALID) consec_n = '0;
      case (state)
        ST_HUNT: begin
          if (blk_type_p0 == BLK_EIEOS) begin
            vld_n   = 1'b1;
            ctl_n   = 1'b1;
            load_n  = 1'b1;
            state_n = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          case (blk_type_p0)
            BLK_DATA:     vld_n = 1'b1;
            BLK_SKP:      begin vld_n = 1'b1; ctl_n = 1'b1; hold_n = 1'b1; end
            BLK_EIEOS:    begin vld_n = 1'b1; ctl_n = 1'b1; load_n = 1'b1; end
            BLK_OTHER_OS: begin vld_n = 1'b1; ctl_n = 1'b1; end
            BLK_EIOS:     begin vld_n = 1'b1; ctl_n = 1'b1; state_n = ST_HUNT; end
            BLK_INVALID: begin
              errp_n    = 1'b1;
              err_cnt_n = sat_inc(err_cnt_p1);
              if (consec + 4'd1 == 4'(ERR_LIMIT)) begin
                state_n  = ST_HUNT;
                consec_n = '0;
              end else begin
                consec_n = consec + 4'd1;
              end
            end
            default: ;
          endcase
        end
        default: state_n = ST_HUNT;
      endcase
    end
  end

  // p0 -> p1: classification result registered onto the descrambler interface
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HUNT;
      consec     <= '0;
      data_p1    <= '0;
      vld_p1     <= 1'b0;
      ctl_p1     <= 1'b0;
      load_p1    <= 1'b0;
      hold_p1    <= 1'b0;
      errp_p1    <= 1'b0;
      locked_p1  <= 1'b0;
      err_cnt_p1 <= '0;
    end else begin
      state      <= state_n;
      consec     <= consec_n;
      vld_p1     <= vld_n;
      ctl_p1     <= ctl_n;
      load_p1    <= load_n;
      hold_p1    <= hold_n;
      errp_p1    <= errp_n;
      locked_p1  <= (state_n == ST_LOCKED);
      err_cnt_p1 <= err_cnt_n;
      if (vld_n) data_p1 <= in_data;
    end
  end

  assign out_data      = data_p1;
  assign out_valid     = vld_p1;
  assign out_is_ctl    = ctl_p1;
  assign out_lfsr_load = load_p1;
  assign out_lfsr_hold = hold_p1;
  assign locked        = locked_p1;
  assign err_pulse     = errp_p1;
  assign err_count     = err_cnt_p1;

endmodule
